or_logic_pipe: RTL and testbench



---
 rtl/or_logic_pipe.sv | 99 +++++++++
 tb/tb_or_logic_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/or_logic_pipe.sv
// Pipelined N-bit bitwise logic unit (OR/AND/XOR/NOR) with valid/ready handshakes on both sides.
// Optional LOGIC_FLAGS_EN adds zero/parity outputs carried alongside the result.
module or_logic_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
`ifdef LOGIC_FLAGS_EN
    output logic             zero,
    output logic             parity,
`endif
    input  logic             out_ready
);

    // Handshake: a transfer happens on an edge where valid && ready; a producer
    // seeing ready low must hold its payload, and valid never depends on ready.

`ifdef LOGIC_FLAGS_EN
    localparam int DW = WIDTH + 2;
`else
    localparam int DW = WIDTH;
`endif

    logic [WIDTH-1:0]  res;
    logic [DW-1:0]     ent;
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] ld;
    logic [DW-1:0]     d [STAGES];

    always_comb begin
        case (op)
            2'b00:   res = in1 | in2;
            2'b01:   res = in1 & in2;
            2'b10:   res = in1 ^ in2;
            default: res = ~(in1 | in2);
        endcase
    end

`ifdef LOGIC_FLAGS_EN
    assign ent = {^res, ~|res, res};
`else
    assign ent = res;
`endif

    // A stage loads when it is empty or its occupant moves on; evaluated from
    // the output back so a drain ripples through the whole pipe in one cycle.
    always_comb begin
        logic nxt;
        nxt = out_ready;
        ld  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld[k] = !v[k] || nxt;
            nxt   = ld[k];
        end
    end

    assign in_ready = ld[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d[k] <= '0;
            end
        end else begin
            if (ld[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    d[0] <= ent;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (ld[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) begin
                        d[k] <= d[k-1];
                    end
                end
            end
        end
    end

    assign out       = d[STAGES-1][WIDTH-1:0];
    assign out_valid = v[STAGES-1];

`ifdef LOGIC_FLAGS_EN
    assign zero   = d[STAGES-1][WIDTH];
    assign parity = d[STAGES-1][WIDTH+1];
`endif

endmodule

// File: tb/tb_or_logic_pipe.sv
// Directed bench for or_logic_pipe: an 8-bit/2-stage instance and a 1-bit/1-stage instance.
// Flag checks are included when LOGIC_FLAGS_EN is defined.
module tb_or_logic_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in1, in2, out;
    logic [1:0] op;
    logic       in_valid, in_ready, out_valid, out_ready;

    logic       b_in1, b_in2, b_out;
    logic [1:0] b_op;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;

`ifdef LOGIC_FLAGS_EN
    logic zero, parity, b_zero, b_parity;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  stream_exp [4];
    logic [15:0] tt;

    always #5 clk = ~clk;

    or_logic_pipe #(.WIDTH(8), .STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .op(op),
        .in_valid(in_valid), .in_ready(in_ready), .out(out), .out_valid(out_valid),
`ifdef LOGIC_FLAGS_EN
        .zero(zero), .parity(parity),
`endif
        .out_ready(out_ready)
    );

    or_logic_pipe #(.WIDTH(1), .STAGES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in1(b_in1), .in2(b_in2), .op(b_op),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out(b_out), .out_valid(b_out_valid),
`ifdef LOGIC_FLAGS_EN
        .zero(b_zero), .parity(b_parity),
`endif
        .out_ready(b_out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o, input logic vld);
        in1      = a;
        in2      = b;
        op       = o;
        in_valid = vld;
    endtask

    initial begin
        stream_exp[0] = 8'hFC;
        stream_exp[1] = 8'h30;
        stream_exp[2] = 8'hCC;
        stream_exp[3] = 8'h03;
        // bit index = op*4 + a*2 + b
        tt = 16'b0001_0110_1000_1110;

        rst_n = 1'b0;
        drive(8'h00, 8'h00, 2'b00, 1'b0);
        out_ready   = 1'b1;
        b_in1       = 1'b0;
        b_in2       = 1'b0;
        b_op        = 2'b00;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_out", 32'(out), 32'h0);
        chk("reset_b_out_valid", 32'(b_out_valid), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'h1);

        // Single OR: 0xA5 | 0x0F = 0xAF, visible one cycle after accept
        drive(8'hA5, 8'h0F, 2'b00, 1'b1);
        tick();
        drive(8'h00, 8'h00, 2'b00, 1'b0);
        chk("single_not_yet_valid", 32'(out_valid), 32'h0);
        tick();
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("single_out", 32'(out), 32'hAF);
        tick();
        chk("single_drained", 32'(out_valid), 32'h0);

        // Back-to-back streaming of all ops, F0 op 3C
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                drive(8'hF0, 8'h3C, 2'(i), 1'b1);
                #1;
                chk("stream_in_ready", 32'(in_ready), 32'h1);
            end else begin
                drive(8'h00, 8'h00, 2'b00, 1'b0);
            end
            tick();
            if (i >= 1) begin
                chk("stream_valid", 32'(out_valid), 32'h1);
                chk("stream_out", 32'(out), 32'(stream_exp[i-1]));
            end
        end
        tick();
        chk("stream_drained", 32'(out_valid), 32'h0);

        // Backpressure: two accepted, third refused until drain
        out_ready = 1'b0;
        drive(8'hF0, 8'h3C, 2'b00, 1'b1);
        tick();
        drive(8'hF0, 8'h3C, 2'b01, 1'b1);
        tick();
        chk("bp_first_valid", 32'(out_valid), 32'h1);
        chk("bp_first_out", 32'(out), 32'hFC);
        drive(8'hF0, 8'h3C, 2'b10, 1'b1);
        #1;
        chk("bp_full_in_ready", 32'(in_ready), 32'h0);
        tick();
        tick();
        chk("bp_hold_out", 32'(out), 32'hFC);
        chk("bp_hold_valid", 32'(out_valid), 32'h1);
        chk("bp_hold_in_ready", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'h1);
        tick();
        drive(8'h00, 8'h00, 2'b00, 1'b0);
        chk("bp_drain_2_valid", 32'(out_valid), 32'h1);
        chk("bp_drain_2_out", 32'(out), 32'h30);
        tick();
        chk("bp_drain_3_valid", 32'(out_valid), 32'h1);
        chk("bp_drain_3_out", 32'(out), 32'hCC);
        tick();
        chk("bp_empty", 32'(out_valid), 32'h0);

        // Asynchronous reset with two transactions in flight
        drive(8'h12, 8'h34, 2'b00, 1'b1);
        tick();
        drive(8'h56, 8'h78, 2'b10, 1'b1);
        tick();
        drive(8'h00, 8'h00, 2'b00, 1'b0);
        out_ready = 1'b0;
        chk("inflight_valid", 32'(out_valid), 32'h1);
        chk("inflight_out", 32'(out), 32'h36);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_out", 32'(out), 32'h0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_no_ghost", 32'(out_valid), 32'h0);
        end

        // 1-bit, 1-stage instance: full truth table, streamed one per cycle
        for (int o = 0; o < 4; o++) begin
            for (int a = 0; a < 2; a++) begin
                for (int b = 0; b < 2; b++) begin
                    b_op       = 2'(o);
                    b_in1      = 1'(a);
                    b_in2      = 1'(b);
                    b_in_valid = 1'b1;
                    #1;
                    chk("tt_in_ready", 32'(b_in_ready), 32'h1);
                    tick();
                    chk("tt_valid", 32'(b_out_valid), 32'h1);
                    chk("tt_out", 32'(b_out), 32'(tt[o*4 + a*2 + b]));
                end
            end
        end
        b_in_valid = 1'b0;
        tick();
        chk("tt_drained", 32'(b_out_valid), 32'h0);

`ifdef LOGIC_FLAGS_EN
        // 0x55 & 0xAA = 0x00 (zero, even parity); 0x55 | 0xAA = 0xFF (even parity)
        drive(8'h55, 8'hAA, 2'b01, 1'b1);
        tick();
        drive(8'h55, 8'hAA, 2'b00, 1'b1);
        tick();
        drive(8'h00, 8'h00, 2'b00, 1'b0);
        chk("flags_and_out", 32'(out), 32'h00);
        chk("flags_and_zero", 32'(zero), 32'h1);
        chk("flags_and_parity", 32'(parity), 32'h0);
        tick();
        chk("flags_or_out", 32'(out), 32'hFF);
        chk("flags_or_zero", 32'(zero), 32'h0);
        chk("flags_or_parity", 32'(parity), 32'h0);
        drive(8'h01, 8'h02, 2'b10, 1'b1);
        tick();
        drive(8'h00, 8'h00, 2'b00, 1'b0);
        tick();
        chk("flags_xor_out", 32'(out), 32'h03);
        chk("flags_xor_parity", 32'(parity), 32'h0);
        drive(8'h01, 8'h00, 2'b10, 1'b1);
        tick();
        drive(8'h00, 8'h00, 2'b00, 1'b0);
        tick();
        chk("flags_odd_parity", 32'(parity), 32'h1);
        chk("flags_odd_zero", 32'(zero), 32'h0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
